// File: rtl/keypad_emulator.sv
// Keypad-side model of a 4x4 matrix: closes one row/column contact per scripted press, with LFSR bounce on make and break.
// Latency: keypad_hori follows contact and keypad_vert by one cycle; start is taken only in IDLE and dropped in every other state.
module keypad_emulator #(
    parameter int          BOUNCE_CYCLES = 48000,
    parameter int          HOLD_W        = 24,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        key_code,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic [3:0]        keypad_vert,
    output logic [3:0]        keypad_hori,
    output logic              busy,
    output logic              done,
    output logic              contact
);

    localparam int BW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int CW = (BW > HOLD_W) ? BW : HOLD_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOUNCE_IN,
        S_HOLD,
        S_BOUNCE_OUT,
        S_DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [15:0]       lfsr;
    logic [3:0]        key_lat;
    logic [HOLD_W-1:0] hold_lat;

    logic [15:0] lfsr_nxt;
    logic        bounce_last;
    logic        hold_last;

    // Fibonacci taps 16,14,13,11 shifting toward bit 0.
    assign lfsr_nxt    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign bounce_last = (cnt == CW'(BOUNCE_CYCLES - 1));
    assign hold_last   = (cnt == CW'(hold_lat - HOLD_W'(1)));

    // contact is loaded with the value it must show in the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lfsr     <= LFSR_SEED;
            key_lat  <= '0;
            hold_lat <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            contact  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key_lat  <= key_code;
                        hold_lat <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        contact  <= lfsr[0];
                        state    <= S_BOUNCE_IN;
                    end
                end
                S_BOUNCE_IN: begin
                    lfsr <= lfsr_nxt;
                    if (bounce_last) begin
                        cnt     <= '0;
                        contact <= 1'b1;
                        state   <= S_HOLD;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        contact <= lfsr_nxt[0];
                    end
                end
                S_HOLD: begin
                    if (hold_last) begin
                        cnt     <= '0;
                        contact <= lfsr[0];
                        state   <= S_BOUNCE_OUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_BOUNCE_OUT: begin
                    lfsr <= lfsr_nxt;
                    if (bounce_last) begin
                        cnt     <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        contact <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        contact <= lfsr_nxt[0];
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    contact <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keypad_hori <= 4'b0000;
        end else if (contact && keypad_vert[key_lat[1:0]]) begin
            keypad_hori <= 4'b0001 << key_lat[3:2];
        end else begin
            keypad_hori <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: each press pushes its per-cycle expected outputs, a negedge monitor pops and compares.
module tb_keypad_emulator;

    localparam int          BC   = 8;
    localparam int          HW   = 24;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    key_code = 4'h0;
    logic [HW-1:0] hold_cycles = '0;
    logic [3:0]    keypad_vert = 4'h0;
    logic [3:0]    keypad_hori;
    logic          busy;
    logic          done;
    logic          contact;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit mon_on = 1'b0;
    string cur_tag = "idle";
    logic [6:0] exp_q[$];
    logic [15:0] m_lfsr = SEED;

    keypad_emulator #(
        .BOUNCE_CYCLES(BC),
        .HOLD_W       (HW),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key_code   (key_code),
        .hold_cycles(hold_cycles),
        .keypad_vert(keypad_vert),
        .keypad_hori(keypad_hori),
        .busy       (busy),
        .done       (done),
        .contact    (contact)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Packed as {hori[3:0], busy, done, contact}.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mon_on && exp_q.size() > 0) begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check_val(cur_tag, {keypad_hori, busy, done, contact}, e);
        end
    end

    // Drives one start and pushes the expected trace for cycles 1..T+1 (T = done cycle).
    task automatic press(input logic [3:0] key, input int hold, input logic [3:0] vert, input string tag);
        int h, t;
        logic c, prev_c;
        logic [3:0] hori;
        @(negedge clk);
        cur_tag     = tag;
        key_code    = key;
        hold_cycles = HW'(hold);
        keypad_vert = vert;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        h = (hold == 0) ? 1 : hold;
        t = 2 * BC + h + 1;
        prev_c = 1'b0;
        for (int k = 1; k <= t + 1; k++) begin
            if ((k <= BC) || (k > BC + h && k < t)) begin
                c = m_lfsr[0];
                m_lfsr = lfsr_step(m_lfsr);
            end else if (k > BC && k <= BC + h) begin
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            hori = (prev_c && vert[key[1:0]]) ? (4'b0001 << key[3:2]) : 4'b0000;
            exp_q.push_back({hori, (k < t), (k == t), c});
            prev_c = c;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
        check_val({tag, "_drain"}, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        #1 reset = 1'b1;
        #1 check_val("reset_out", {keypad_hori, busy, done, contact}, 7'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_on = 1'b1;

        // Idle with a swept column drive: nothing may appear.
        @(posedge clk);
        #1;
        cur_tag = "idle";
        for (int i = 0; i < 20; i++) exp_q.push_back(7'd0);
        for (int i = 0; i < 20; i++) begin
            keypad_vert = 4'b0001 << (i % 4);
            @(posedge clk);
            #1;
        end
        drain("idle");

        d0 = done_cnt;
        press(4'b0110, 20, 4'b0100, "clean");
        drain("clean");
        check_val("clean_done_cnt", done_cnt - d0, 1);

        press(4'b0110, 20, 4'b0001, "col_mismatch");
        drain("col_mismatch");

        press(4'b0000, 0, 4'b0001, "bounce");
        drain("bounce");

        // Second start during the first press, with column 3 also driven so a wrongly taken key F would show on row 3.
        d0 = done_cnt;
        fork
            press(4'b0000, 10, 4'b1001, "busy_start");
            begin
                repeat (6) @(negedge clk);
                key_code = 4'hF;
                start    = 1'b1;
                @(negedge clk);
                start    = 1'b0;
            end
        join
        drain("busy_start");
        check_val("busy_start_done_cnt", done_cnt - d0, 1);

        // Reset in the middle of HOLD.
        d0 = done_cnt;
        press(4'b0101, 20, 4'b0010, "pre_reset");
        repeat (12) @(negedge clk);
        check_val("pre_reset_hori", keypad_hori, 4'b0010);
        mon_on = 1'b0;
        exp_q.delete();
        #2 reset = 1'b1;
        #1 check_val("mid_reset_out", {keypad_hori, busy, done, contact}, 7'd0);
        repeat (4) @(negedge clk);
        check_val("in_reset_out", {keypad_hori, busy, done, contact}, 7'd0);
        reset  = 1'b0;
        m_lfsr = SEED;
        repeat (2) @(negedge clk);
        check_val("reset_no_done", done_cnt - d0, 0);
        mon_on = 1'b1;
        press(4'b1111, 3, 4'b1000, "post_reset");
        drain("post_reset");
        check_val("post_reset_done_cnt", done_cnt - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
